// File: rtl/channel_dispatcher.sv
// channel_dispatcher: steers one token per cycle to the least-loaded ready channel,
// holding it until taken, and publishes a saturating latency estimate upstream.
module channel_dispatcher #(
    parameter int PC_WIDTH = 8,
    parameter int CC_ID = 2,
    parameter int N_CHANNELS = 4,
    parameter int LATENCY_COUNT_WIDTH = 10,
    parameter int STALL_COUNT_WIDTH = 16,
    localparam int DWIDTH = PC_WIDTH + CC_ID,
    localparam int LW = LATENCY_COUNT_WIDTH,
    localparam int TW = $clog2(N_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DWIDTH-1:0]            in_data,
    output logic                         in_ready,
    output logic [LW-1:0]                in_latency,
    output logic [N_CHANNELS-1:0]        out_valid,
    output logic [DWIDTH-1:0]            out_data,
    input  logic [N_CHANNELS-1:0]        out_ready,
    input  logic [N_CHANNELS*LW-1:0]     out_latency,
    output logic [TW-1:0]                last_target,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_next;
    logic hold, accept;
    logic [TW-1:0] sel, idx;
    logic [LW:0] best, key, lat_inc;
    logic [LW-1:0] min_lat;

    assign hold = state == HOLD;
    assign in_ready = !hold || out_ready[last_target];
    assign accept = in_valid && in_ready;
    assign out_valid = hold ? N_CHANNELS'(1) << last_target : '0;

    always_comb begin
        state_next = accept ? HOLD : (hold && out_ready[last_target]) ? IDLE : state;
    end

    // Round-robin search from last_target+1; strict < keeps the first minimum found.
    always_comb begin
        sel = TW'((int'(last_target) + 1) % N_CHANNELS);
        best = {~out_ready[sel], out_latency[sel*LW +: LW]};
        idx = '0;
        key = '0;
        for (int k = 1; k < N_CHANNELS; k++) begin
            idx = TW'((int'(last_target) + 1 + k) % N_CHANNELS);
            key = {~out_ready[idx], out_latency[idx*LW +: LW]};
            if (key < best) begin
                best = key;
                sel = idx;
            end
        end
    end

    always_comb begin
        min_lat = out_latency[LW-1:0];
        for (int i = 1; i < N_CHANNELS; i++)
            min_lat = out_latency[i*LW +: LW] < min_lat ? out_latency[i*LW +: LW] : min_lat;
        lat_inc = {1'b0, min_lat} + {{LW{1'b0}}, hold};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            out_data <= '0;
            last_target <= TW'(N_CHANNELS - 1);
            in_latency <= LW'(1);
            stall_count <= '0;
        end else begin
            state <= state_next;
            in_latency <= lat_inc[LW] ? '1 : lat_inc[LW-1:0];
            if (accept) begin
                out_data <= in_data;
                last_target <= sel;
            end
            if (hold && !out_ready[last_target] && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(out_valid));
    a_stable: assert property (@(posedge clk) disable iff (!rst)
        (hold && !out_ready[last_target]) |=> ($stable(out_data) && $stable(last_target)));
endmodule

// File: tb/tb_channel_dispatcher.sv
// tb_channel_dispatcher: directed stimulus with a target/data scoreboard for channel_dispatcher.
module tb_channel_dispatcher;
    logic        clk, rst, in_valid, in_ready;
    logic [9:0]  in_data, out_data, in_latency;
    logic [3:0]  out_valid, out_ready;
    logic [39:0] out_latency;
    logic [1:0]  last_target;
    logic [15:0] stall_count;
    logic [11:0] exp_q[$];
    logic [11:0] e;
    int n_cmp = 0, n_bad = 0;

    channel_dispatcher dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .in_latency(in_latency), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_latency(out_latency), .last_target(last_target),
        .stall_count(stall_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [9:0] d, input logic [1:0] t);
        int n = 0;
        in_valid = 1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept_wait", n, 0);
        exp_q.push_back({t, d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        in_valid = 0;
        repeat (c) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        int ch;
        if (rst && |(out_valid & out_ready)) begin
            ch = 0;
            for (int i = 0; i < 4; i++) if (out_valid[i]) ch = i;
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("sb_target", ch, e[11:10]);
                check("sb_data", out_data, e[9:0]);
            end
        end
    end

    initial begin
        int n;
        rst = 0; in_valid = 0; in_data = 0; out_ready = '1; out_latency = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_in_latency", in_latency, 1);
        check("rst_last_target", last_target, 3);
        check("rst_stall", stall_count, 0);
        check("rst_data", out_data, 0);
        rst = 1;
        idle(1);

        out_latency = {10'd3, 10'd9, 10'd3, 10'd7};
        send(10'h2A5, 1);
        check("lat_order_valid", out_valid, 4'b0010);
        send(10'h111, 3);
        check("rr_tie_valid", out_valid, 4'b1000);
        check("in_latency_hold", in_latency, 4);
        idle(3);
        check("in_latency_idle", in_latency, 3);

        out_latency = {4{10'd5}};
        for (int i = 0; i < 8; i++) send(10'h100 + 10'(i), 2'(i));
        idle(3);

        out_ready = 4'b0100;
        out_latency = {10'd0, 10'h3FF, 10'd0, 10'd0};
        send(10'h155, 2);
        in_valid = 0;
        out_ready = 4'b0000;
        out_latency = {4{10'h3FF}};
        repeat (5) @(posedge clk);
        #1;
        check("bp_stall5", stall_count, 5);
        check("bp_data", out_data, 10'h155);
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 4'b0100);
        check("sat_in_latency", in_latency, 10'h3FF);
        repeat (65535) @(posedge clk);
        #1;
        check("stall_sat", stall_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("stall_sat_hold", stall_count, 16'hFFFF);
        check("bp_data_late", out_data, 10'h155);
        out_ready = 4'b0100;
        idle(1);
        check("bp_done_valid", out_valid, 0);

        out_ready = 4'b0000;
        out_latency = {4{10'd4}};
        send(10'h0AA, 3);
        in_valid = 0;
        check("no_ready_valid", out_valid, 4'b1000);
        #3;
        rst = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_last_target", last_target, 3);
        check("arst_stall", stall_count, 0);
        check("arst_in_latency", in_latency, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1;
        out_ready = '1;
        @(posedge clk);
        #1;
        send(10'h3C3, 0);
        check("post_rst_valid", out_valid, 4'b0001);
        in_valid = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/channel_dispatcher.md
Name: channel_dispatcher

Overview:
- Producer-side counterpart of the per-core channel FIFO.
- Accepts one instruction token (PC plus CC id) per cycle from the fetch/fork logic.
- Steers each token to one of N_CHANNELS downstream channels, using the channels' ready flags and the latency estimates they advertise.
- Publishes a registered, saturating latency estimate upstream, so dispatchers can be cascaded.

Parameters:
PC_WIDTH, 8, program-counter width of a token
CC_ID, 2, CC-id field width; token data width DWIDTH = PC_WIDTH+CC_ID, CC id in bits [CC_ID-1:0]
N_CHANNELS, 4, number of downstream channels (2..16)
LATENCY_COUNT_WIDTH, 10, width of every latency estimate
STALL_COUNT_WIDTH, 16, width of the stall statistics counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  upstream token valid
in_data  in  DWIDTH  upstream token
in_ready  out  1  dispatcher can accept a token this cycle
in_latency  out  LATENCY_COUNT_WIDTH  registered estimate of wait before service
out_valid  out  N_CHANNELS  one-hot valid, one bit per channel
out_data  out  DWIDTH  token, shared by all channels
out_ready  in  N_CHANNELS  per-channel ready (not full)
out_latency  in  N_CHANNELS*LATENCY_COUNT_WIDTH  per-channel latency; channel i at [i*LW +: LW]
last_target  out  $clog2(N_CHANNELS)  index of the last accepted target
stall_count  out  STALL_COUNT_WIDTH  saturating count of cycles a pending token waited

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, last_target=N_CHANNELS-1, in_latency=1, stall_count=0, state=IDLE. Reset mid-HOLD drops the held token; no partial valid may remain.
- States: IDLE (no held token), HOLD (token held, out_valid one-hot).
- in_ready = (state==IDLE) | out_ready[target]. This is a combinational path, giving full throughput of one token per cycle.
- Accept happens when in_valid & in_ready. Data is registered, and out_valid[sel] rises on the next cycle (1-cycle latency). State becomes or stays HOLD.
- Completion happens when out_valid[target] & out_ready[target]. With no simultaneous accept, state goes to IDLE and out_valid goes to 0.
- Simultaneous completion and accept: the new token replaces the old one with no bubble.
- Selection at accept time: choose the minimum of key_i = {~out_ready[i], out_latency[i]}. Ready channels always beat non-ready ones.
- Ties: round-robin. Search starts at (last_target+1) mod N and the first minimum found wins. last_target updates on accept.
- If no channel is ready, the token is still accepted (when IDLE) and held. Its target is frozen.
- While HOLD: out_data and the target never change until completion. There is no retargeting, even if other channels become ready.
- A latency of all-ones is a saturated value and is compared as-is (largest).
- in_latency is registered each cycle: min over channels of out_latency, plus 1 if state==HOLD, saturating at all-ones.
- stall_count increments in every HOLD cycle where out_ready[target]=0. It saturates at all-ones and never wraps.
- Invariant: at most one bit of out_valid is set. Assertions check this and check the stability of data and target while held.

Test Plan:
- Reset, then check idle outputs: out_valid=0, in_ready=1, in_latency=1, last_target=3, stall_count=0.
- Latency ordering: all ready, latencies {7,3,9,3}, token 0x2A5 -> out_valid=4'b0010. Next token with the same latencies -> 4'b1000 (round-robin tie).
- Back-to-back stream: 8 tokens, out_ready all 1, equal latencies -> targets 0,1,2,3,0,1,2,3; in_ready stays 1; one token per cycle, no bubbles.
- Backpressure: only ch2 ready, with latency 0x3FF; ch0 latency 0 but not ready -> ch2 chosen. Then drop ch2 ready for 5 cycles -> out_data stable, in_ready=0, stall_count=5.
- Saturation: all latencies 0x3FF while HOLD -> in_latency=0x3FF (no wrap). Force stall_count near max -> holds at 0xFFFF.
- Async reset asserted mid-HOLD between clock edges -> out_valid clears immediately. After release, the first token is dispatched normally.
